load_store_unit: RTL and testbench

//  Sits between the core memory stage and data_mem (word-indexed, async read, sync word write).

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed RV32I load/store front end for a word-wide
// data_mem (async read, sync whole-word write). Sub-word loads are extracted
// and sign/zero-extended. SB/SH use a read-modify-write because data_mem can
// only write complete words.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned LH/LHU/SH
// and LW/SW with resp_err. Without it, the low address bits are ignored down
// to natural alignment.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // funct3[1:0] encodes the access size, funct3[2] marks an unsigned load
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic [1:0]  lane_q;   // byte offset within the addressed word
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;

  logic        illegal_f3;
  logic        out_of_range;
  logic        misaligned;
  logic        req_err;

  // Pick the addressed byte/half out of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3[1:0])
      SZ_BYTE: return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Replace one byte/half lane of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] old_word,
                                              input logic [31:0] wdata);
    logic [31:0] merged;
    merged = old_word;
    if (f3[1:0] == SZ_BYTE) merged[{lane, 3'b000} +: 8] = wdata[7:0];
    else                    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return merged;
  endfunction

  assign req_ready = (state == IDLE) & rst;

  // Classify the presented request; used only at the accept edge.
  always_comb begin
    illegal_f3   = 1'b0;
    out_of_range = 1'b0;
    misaligned   = 1'b0;
    if (req_we) illegal_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else        illegal_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_funct3[1:0] == SZ_HALF) && req_addr[0]) ||
                 ((req_funct3[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  assign req_err = illegal_f3 | out_of_range | misaligned;

  // Transaction FSM; every output except req_ready is registered here.
  // NOTE: state and registered outputs use non-blocking assignments so all
  // of them update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lane_q     <= 2'b00;
      funct3_q   <= 3'b000;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_A      <= 32'h0;
      mem_WD     <= 32'h0;
      mem_WE     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lane_q   <= req_addr[1:0];
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            mem_A    <= {2'b00, req_addr[31:2]};
            if (req_err) begin
              // Rejected requests skip memory entirely.
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && (req_funct3[1:0] == SZ_WORD)) begin
              // Full-word store needs no read of the old contents.
              mem_WD <= req_wdata;
              mem_WE <= 1'b1;
              state  <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (!we_q) begin
            resp_rdata <= load_extend(funct3_q, lane_q, mem_RD);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_WD <= store_merge(funct3_q, lane_q, mem_RD, wdata_q);
            mem_WE <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          mem_WE     <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a behavioural
// data_mem, a response scoreboard and latency/write-enable checks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  // Behavioural data_mem: async read, sync write, plus a preload port.
  logic [31:0] mem [0:1023];
  logic        pl_we;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  assign mem_RD = (mem_A < 32'd1024) ? mem[mem_A[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (mem_WE && (mem_A < 32'd1024)) mem[mem_A[9:0]] <= mem_WD;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow it to its response and check it end to end.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_wes, input logic [31:0] exp_wd);
    int          waits;
    int          lat;
    int          wes;
    logic [31:0] wd_seen;
    resp_t       want;
    waits   = 0;
    wes     = 0;
    wd_seen = 32'h0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (!req_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    check({tag, " ready_wait"}, 32'(waits), 32'd0);
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    #1;
    // Scramble the request bus: it must be ignored once accepted.
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'hDEAD_BEEF;
    check({tag, " mem_A"}, mem_A, {2'b00, addr[31:2]});
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (mem_WE) begin
        wes++;
        wd_seen = mem_WD;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (mem_WE) wes++;
    check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " we_cycles"}, 32'(wes), 32'(exp_wes));
    if (exp_wes > 0) check({tag, " mem_WD"}, wd_seen, exp_wd);
    if (resp_valid && sb_q.size() > 0) begin
      want = sb_q.pop_front();
      check({tag, " rdata"}, resp_rdata, want.rdata);
      check({tag, " err"}, {31'b0, resp_err}, {31'b0, want.err});
    end
    @(posedge clk);
    #1;
    check({tag, " pulse_end"}, {31'b0, resp_valid}, 32'd0);
    check({tag, " rdata_hold"}, resp_rdata, exp_rdata);
    check({tag, " ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int bad;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pl_we      = 1'b1;
    pl_idx     = 10'd240;
    pl_data    = 32'h0000_0020;
    @(posedge clk);
    #1;
    pl_idx  = 10'd241;
    pl_data = 32'h0;
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset resp_err",   {31'b0, resp_err},   32'd0);
    check("reset mem_WE",     {31'b0, mem_WE},     32'd0);
    check("reset req_ready",  {31'b0, req_ready},  32'd0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset mem_A",      mem_A,      32'h0);
    check("reset mem_WD",     mem_WD,     32'h0);
    @(posedge clk);
    #1;
    pl_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    //      tag         we    f3      addr          wdata         rdata         err   lat we  wd
    do_req("LW 3C0",   1'b0, 3'b010, 32'h0000_03C0, 32'h0,        32'h0000_0020, 1'b0, 2, 0, 32'h0);
    do_req("SB 3C1",   1'b1, 3'b000, 32'h0000_03C1, 32'h0000_00FF, 32'h0,        1'b0, 3, 1, 32'h0000_FF20);
    do_req("LB 3C1",   1'b0, 3'b000, 32'h0000_03C1, 32'h0,        32'hFFFF_FFFF, 1'b0, 2, 0, 32'h0);
    do_req("LBU 3C1",  1'b0, 3'b100, 32'h0000_03C1, 32'h0,        32'h0000_00FF, 1'b0, 2, 0, 32'h0);
    do_req("SH 3C2",   1'b1, 3'b001, 32'h0000_03C2, 32'h0000_8001, 32'h0,        1'b0, 3, 1, 32'h8001_FF20);
    do_req("LH 3C2",   1'b0, 3'b001, 32'h0000_03C2, 32'h0,        32'hFFFF_8001, 1'b0, 2, 0, 32'h0);
    do_req("LHU 3C2",  1'b0, 3'b101, 32'h0000_03C2, 32'h0,        32'h0000_8001, 1'b0, 2, 0, 32'h0);
    do_req("LB 3C3",   1'b0, 3'b000, 32'h0000_03C3, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 0, 32'h0);
    do_req("LBU 3C0",  1'b0, 3'b100, 32'h0000_03C0, 32'h0,        32'h0000_0020, 1'b0, 2, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("LW 3C1",   1'b0, 3'b010, 32'h0000_03C1, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0);
    do_req("LH 3C3",   1'b0, 3'b001, 32'h0000_03C3, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0);
`else
    do_req("LW 3C1",   1'b0, 3'b010, 32'h0000_03C1, 32'h0,        32'h8001_FF20, 1'b0, 2, 0, 32'h0);
    do_req("LH 3C3",   1'b0, 3'b001, 32'h0000_03C3, 32'h0,        32'hFFFF_8001, 1'b0, 2, 0, 32'h0);
`endif
    do_req("LD f3 011", 1'b0, 3'b011, 32'h0000_03C0, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0);
    do_req("LW 1000",  1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0);
    do_req("ST f3 100", 1'b1, 3'b100, 32'h0000_03C4, 32'h0000_00AA, 32'h0,        1'b1, 1, 0, 32'h0);
    check("mem240 after errors", mem[240], 32'h8001_FF20);
    do_req("SW 3C4",   1'b1, 3'b010, 32'h0000_03C4, 32'h1234_5678, 32'h0,        1'b0, 2, 1, 32'h1234_5678);
    do_req("LW 3C4",   1'b0, 3'b010, 32'h0000_03C4, 32'h0,        32'h1234_5678, 1'b0, 2, 0, 32'h0);

    // SB aborted by a reset pulse while the FSM sits in READ.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0000_03C0;
    req_wdata  = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort in READ mem_WE", {31'b0, mem_WE}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("abort rst req_ready", {31'b0, req_ready}, 32'd0);
    check("abort rst mem_WE",    {31'b0, mem_WE},    32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort req_ready", {31'b0, req_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid || mem_WE) bad++;
    end
    check("abort no resp/WE", 32'(bad), 32'd0);
    check("abort resp_rdata", resp_rdata, 32'h0);
    check("abort mem240", mem[240], 32'h8001_FF20);

    do_req("LW 3C0 post", 1'b0, 3'b010, 32'h0000_03C0, 32'h0,     32'h8001_FF20, 1'b0, 2, 0, 32'h0);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
